// File: rtl/fixed_point_mul_vec.sv
// fixed_point_mul_vec: multi-lane signed fixed-point multiplier, two pipeline stages,
// per-transaction rounding, output saturation, valid/ready backpressure and sticky saturation status.
module fixed_point_mul_vec #(
    parameter int LANES     = 4,
    parameter int DATA_W    = 14,
    parameter int FRAC_BITS = 9,
    parameter int OUT_W     = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  a_in,
    input  logic [LANES*DATA_W-1:0]  b_in,
    input  logic [1:0]               rnd_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   res_out,
    output logic [LANES-1:0]         sat_out,
    output logic                     sat_sticky,
    input  logic                     sat_clr
);
    localparam int PW = 2*DATA_W;
    localparam int W  = 2*DATA_W - FRAC_BITS + 1;
    localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] MIN_V = ~MAX_V;

    logic                    en, load;
    logic                    v1_q, v1_d, v2_q, v2_d, sticky_q, sticky_d;
    logic [1:0]              mode_q, mode_d;
    logic [LANES*PW-1:0]     prod, p_q, p_d;
    logic [LANES*OUT_W-1:0]  res_n, res_q, res_d;
    logic [LANES-1:0]        sat_n, sat_q, sat_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W-1:0]    a, b;
        logic signed [PW-1:0] p;
        logic signed [W-1:0]  t, r;
        logic                 g, s, inc;
        assign a = a_in[i*DATA_W +: DATA_W];
        assign b = b_in[i*DATA_W +: DATA_W];
        // sign-extended operands make the low PW bits the exact two's complement product
        assign prod[i*PW +: PW] = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
        assign p   = p_q[i*PW +: PW];
        assign t   = {p[PW-1], p[PW-1:FRAC_BITS]};
        assign g   = p[FRAC_BITS-1];
        assign s   = |p[FRAC_BITS-2:0];
        assign inc = mode_q == 2'd0 ? 1'b0 :
                     mode_q == 2'd1 ? g :
                     mode_q == 2'd2 ? g & (s | t[0]) : g & s;
        assign r   = t + {{(W-1){1'b0}}, inc};
        assign sat_n[i] = (r > MAX_V) || (r < MIN_V);
        assign res_n[i*OUT_W +: OUT_W] = r > MAX_V ? MAX_V[OUT_W-1:0] :
                                         r < MIN_V ? MIN_V[OUT_W-1:0] : r[OUT_W-1:0];
    end

    always_comb begin
        en       = !(v2_q && !out_ready);
        load     = en && v1_q;
        v1_d     = en ? in_valid : v1_q;
        v2_d     = en ? v1_q : v2_q;
        mode_d   = (en && in_valid) ? rnd_mode : mode_q;
        p_d      = (en && in_valid) ? prod : p_q;
        res_d    = load ? res_n : res_q;
        sat_d    = load ? sat_n : sat_q;
        sticky_d = (load && |sat_n) || (sticky_q && !sat_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            mode_q   <= 2'd0;
            p_q      <= '0;
            res_q    <= '0;
            sat_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            mode_q   <= mode_d;
            p_q      <= p_d;
            res_q    <= res_d;
            sat_q    <= sat_d;
            sticky_q <= sticky_d;
        end
    end

    assign in_ready   = en;
    assign out_valid  = v2_q;
    assign res_out    = res_q;
    assign sat_out    = sat_q;
    assign sat_sticky = sticky_q;
endmodule

// File: tb/tb_fixed_point_mul_vec.sv
// tb_fixed_point_mul_vec: directed vectors checked against a value-level rounding/saturation model
// and a handful of hand-computed literals.
module tb_fixed_point_mul_vec;
    localparam int LANES = 4, DW = 14, FB = 9, OW = 14;
    localparam longint ONE  = longint'(1) << FB;
    localparam longint MAXV = (longint'(1) << (OW-1)) - 1;
    localparam longint MINV = -(longint'(1) << (OW-1));

    logic clk = 0, rst = 0, in_valid = 0, out_ready = 1, sat_clr = 0;
    logic in_ready, out_valid, sat_sticky;
    logic [LANES*DW-1:0] a_in = '0, b_in = '0;
    logic [1:0] rnd_mode = 2'd0;
    logic [LANES*OW-1:0] res_out;
    logic [LANES-1:0] sat_out;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    fixed_point_mul_vec #(.LANES(LANES), .DATA_W(DW), .FRAC_BITS(FB), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .rnd_mode(rnd_mode), .out_valid(out_valid),
        .out_ready(out_ready), .res_out(res_out), .sat_out(sat_out),
        .sat_sticky(sat_sticky), .sat_clr(sat_clr)
    );

    typedef struct packed {
        logic [LANES*OW-1:0] res;
        logic [LANES-1:0]    sat;
    } exp_t;

    exp_t q[$];
    logic signed [OW-1:0] log0[$];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Real-valued view: product = t + fr/ONE with 0 <= fr < ONE, then round and clamp.
    function automatic exp_t model(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                                   input logic [1:0] m);
        exp_t e;
        longint p, fr, t, r;
        for (int i = 0; i < LANES; i++) begin
            p  = longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
            fr = ((p % ONE) + ONE) % ONE;
            t  = (p - fr) / ONE;
            r  = t;
            if (m == 2'd1 && fr*2 >= ONE) r++;
            if (m == 2'd2 && (fr*2 > ONE || (fr*2 == ONE && t % 2 != 0))) r++;
            if (m == 2'd3 && fr*2 > ONE) r++;
            e.sat[i] = (r > MAXV) || (r < MINV);
            if (r > MAXV) r = MAXV;
            if (r < MINV) r = MINV;
            e.res[i*OW +: OW] = r[OW-1:0];
        end
        return e;
    endfunction

    function automatic logic [LANES*DW-1:0] pk(input int v0, input int v1, input int v2, input int v3);
        logic [LANES*DW-1:0] r;
        int v[4];
        v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) r[i*DW +: DW] = v[i][DW-1:0];
        return r;
    endfunction

    logic prev_hold = 0, prev_clr = 0;
    logic [LANES*OW-1:0] prev_res;
    logic [LANES-1:0] prev_sat;
    logic exp_sticky = 0;

    always @(negedge clk) begin : mon
        logic fresh;
        exp_t e;
        if (!rst) begin
            q.delete();
            exp_sticky = 0;
            prev_hold = 0;
            prev_clr = 0;
        end else begin
            fresh = out_valid && !prev_hold;
            if (prev_hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_res", res_out, prev_res);
                chk("hold_sat", sat_out, prev_sat);
            end
            if (fresh) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                    exp_sticky = exp_sticky && !prev_clr;
                end else begin
                    e = q[0];
                    chk("res", res_out, e.res);
                    chk("sat", sat_out, e.sat);
                    exp_sticky = (|e.sat) || (exp_sticky && !prev_clr);
                end
            end else exp_sticky = exp_sticky && !prev_clr;
            chk("sticky", sat_sticky, exp_sticky);
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (!out_valid) chk("idle_in_ready", in_ready, 1);
            if (out_valid && out_ready && q.size() != 0) begin
                void'(q.pop_front());
                log0.push_back($signed(res_out[OW-1:0]));
            end
            if (in_valid && in_ready) q.push_back(model(a_in, b_in, rnd_mode));
            prev_hold = out_valid && !out_ready;
            prev_res = res_out;
            prev_sat = sat_out;
            prev_clr = sat_clr;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic drive(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b, input logic [1:0] m);
        logic acc;
        int n;
        in_valid = 1; a_in = a; b_in = b; rnd_mode = m; n = 0;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 100);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic one(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b, input logic [1:0] m,
                       input int lane, input int er, input logic es, input string nm);
        int n;
        drive(a, b, m);
        in_valid = 0; n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        chk({nm, "_lat"}, n, 2);
        chk({nm, "_res"}, $signed(res_out[lane*OW +: OW]), er);
        chk({nm, "_sat"}, sat_out[lane], es);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 60) begin @(posedge clk); #1; n++; end
        chk({nm, "_drain"}, (q.size() == 0 && !out_valid), 1);
    endtask

    int ra[13] = '{3, 3, 3, 3, 1, 1, 1, 1, -1, -1, -1, 769, 7};
    int rb[13] = '{256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 256, 1, 256};
    int rm[13] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 2, 0, 3, 2};
    int re[13] = '{1, 2, 2, 1, 0, 1, 0, 0, 0, 0, -1, 2, 4};

    initial begin
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_res", res_out, 0);
        chk("rst_sat", sat_out, 0);
        chk("rst_sticky", sat_sticky, 0);
        @(posedge clk); #1; rst = 1;
        chk("rst_in_ready", in_ready, 1);

        one(pk(768, 0, 0, 0), pk(1024, 0, 0, 0), 2'd0, 0, 1536, 0, "basic");
        chk("basic_lane1", $signed(res_out[OW +: OW]), 0);
        @(posedge clk); #1;

        for (int k = 0; k < 13; k++) begin
            one(pk(ra[k], 0, 0, ra[k]), pk(rb[k], 0, 0, rb[k]), rm[k][1:0], 0, re[k], 0, "round");
            @(posedge clk); #1;
        end

        one(pk(0, 8191, -8192, 100), pk(0, 8191, 8191, 100), 2'd1, 1, 8191, 1, "sat_pos");
        chk("sat_neg_res", $signed(res_out[2*OW +: OW]), -8192);
        chk("sat_neg_flag", sat_out[2], 1);
        chk("sat_sticky_set", sat_sticky, 1);
        @(posedge clk); #1;
        sat_clr = 1;
        @(posedge clk); #1; sat_clr = 0;
        @(negedge clk); chk("sat_clr", sat_sticky, 0);
        @(posedge clk); #1;
        drive(pk(0, 8191, 0, 0), pk(0, 8191, 0, 0), 2'd0);
        in_valid = 0; sat_clr = 1;
        @(posedge clk); #1; sat_clr = 0;
        @(negedge clk);
        chk("clr_vs_set_valid", out_valid, 1);
        chk("clr_vs_set_sticky", sat_sticky, 1);
        @(posedge clk); #1;
        sat_clr = 1;
        @(posedge clk); #1; sat_clr = 0;

        for (int pass = 0; pass < 2; pass++) begin
            log0.delete();
            fork
                for (int i = 0; i < 8; i++) begin
                    drive(pk(i*37 - 100, i*5 + 1, -i*200, 8000 - i), pk(300 + i, -256, i*11, 5), 2'(i % 4));
                    if (pass == 1 && i % 2 == 1) begin in_valid = 0; @(posedge clk); #1; end
                end
                begin
                    repeat (3) @(posedge clk);
                    #1; out_ready = 0;
                    repeat (4) @(posedge clk);
                    #1; out_ready = 1;
                end
            join
            in_valid = 0;
            drain("stream");
            chk("stream_count", log0.size(), 8);
        end

        log0.delete();
        drive(pk(3, 0, 0, 0), pk(256, 0, 0, 0), 2'd1);
        drive(pk(3, 0, 0, 0), pk(256, 0, 0, 0), 2'd2);
        drive(pk(5, 0, 0, 0), pk(256, 0, 0, 0), 2'd1);
        drive(pk(5, 0, 0, 0), pk(256, 0, 0, 0), 2'd2);
        in_valid = 0;
        drain("modes");
        chk("modes_count", log0.size(), 4);
        if (log0.size() == 4) begin
            chk("mode_t0", log0[0], 2);
            chk("mode_t1", log0[1], 2);
            chk("mode_t2", log0[2], 3);
            chk("mode_t3", log0[3], 2);
        end

        out_ready = 0;
        drive(pk(8191, 0, 0, 0), pk(8191, 0, 0, 0), 2'd0);
        drive(pk(100, 0, 0, 0), pk(512, 0, 0, 0), 2'd0);
        in_valid = 0;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_sticky", sat_sticky, 1);
        #2; rst = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_res", res_out, 0);
        chk("mid_rst_sat", sat_out, 0);
        chk("mid_rst_sticky", sat_sticky, 0);
        @(negedge clk);
        @(posedge clk); #1; rst = 1; out_ready = 1;
        chk("post_rst_in_ready", in_ready, 1);
        one(pk(-768, 0, 0, 0), pk(1024, 0, 0, 0), 2'd0, 0, -1536, 0, "post_rst");
        @(posedge clk); #1;
        drain("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
